// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one active-low row at a time, debounces
// single-key presses/releases on scan ticks and latches the key for a reader.
module keypad_scanner #(
    parameter int SCAN_TICKS     = 1000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols,
    input  logic       key_read,
    output logic [3:0] rows,
    output logic [7:0] key_data,
    output logic       key_pressed
);
    localparam int PW = (SCAN_TICKS > 2) ? $clog2(SCAN_TICKS) : 1;
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [PW-1:0] PS_MAX = PW'(SCAN_TICKS - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t        state;
    logic [3:0]    sync1, scols, pat, code;
    logic [PW-1:0] ps_cnt;
    logic [DW-1:0] db_cnt;
    logic [1:0]    row_idx, reg_col;
    logic          valid, overrun, tick, one_low, do_reg;

    function automatic logic [1:0] col_of(input logic [3:0] p);
        case (p)
            4'b1110: col_of = 2'd0;
            4'b1101: col_of = 2'd1;
            4'b1011: col_of = 2'd2;
            default: col_of = 2'd3;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= 4'hF;
            scols  <= 4'hF;
            ps_cnt <= '0;
        end else begin
            sync1  <= cols;
            scols  <= sync1;
            ps_cnt <= (ps_cnt == PS_MAX) ? '0 : ps_cnt + 1'b1;
        end
    end

    assign tick    = (ps_cnt == PS_MAX);
    assign one_low = (scols == 4'b1110) || (scols == 4'b1101) ||
                     (scols == 4'b1011) || (scols == 4'b0111);
    // In DEBOUNCE a registration implies scols == pat, so scols serves both cases
    assign reg_col = col_of(scols);
    assign do_reg  = tick &&
                     ((state == SCAN && one_low && DEBOUNCE_TICKS == 1) ||
                      (state == DEBOUNCE && scols == pat &&
                       int'(db_cnt) + 1 == DEBOUNCE_TICKS));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= SCAN;
            row_idx     <= 2'd0;
            db_cnt      <= '0;
            pat         <= 4'hF;
            code        <= 4'h0;
            valid       <= 1'b0;
            overrun     <= 1'b0;
            key_pressed <= 1'b0;
        end else begin
            // Registration beats a coincident read; overrun only if the old key is unread
            if (do_reg) begin
                code    <= {row_idx, reg_col};
                overrun <= valid && !key_read;
                valid   <= 1'b1;
            end else if (key_read) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end

            if (tick) begin
                case (state)
                    SCAN: begin
                        if (one_low) begin
                            pat <= scols;
                            if (DEBOUNCE_TICKS == 1) begin
                                state       <= HELD;
                                key_pressed <= 1'b1;
                            end else begin
                                db_cnt <= DW'(1);
                                state  <= DEBOUNCE;
                            end
                        end else begin
                            row_idx <= row_idx + 2'd1;
                        end
                    end
                    DEBOUNCE: begin
                        if (scols == pat) begin
                            if (int'(db_cnt) + 1 == DEBOUNCE_TICKS) begin
                                db_cnt      <= '0;
                                state       <= HELD;
                                key_pressed <= 1'b1;
                            end else begin
                                db_cnt <= db_cnt + 1'b1;
                            end
                        end else begin
                            db_cnt  <= '0;
                            row_idx <= row_idx + 2'd1;
                            state   <= SCAN;
                        end
                    end
                    HELD: begin
                        if (scols == 4'hF) begin
                            db_cnt <= DW'(1);
                            state  <= RELEASE;
                        end
                    end
                    RELEASE: begin
                        if (scols == 4'hF) begin
                            if (int'(db_cnt) + 1 >= DEBOUNCE_TICKS) begin
                                db_cnt      <= '0;
                                row_idx     <= row_idx + 2'd1;
                                state       <= SCAN;
                                key_pressed <= 1'b0;
                            end else begin
                                db_cnt <= db_cnt + 1'b1;
                            end
                        end else begin
                            db_cnt <= '0;
                            state  <= HELD;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

    assign rows     = ~(4'b0001 << row_idx);
    assign key_data = {valid, overrun, 2'b00, code};

endmodule

// File: tb/tb_keypad_scanner.sv
// Scanner bench: a keypad model answers the row drive, and a tick-level model
// of the scanning/debounce rules predicts rows, key_data and key_pressed.
module tb_keypad_scanner;
    localparam int ST = 4;
    localparam int DT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        key_read = 1'b0;
    logic [3:0]  cols, rows;
    logic [7:0]  key_data;
    logic        key_pressed;
    logic [15:0] press = '0;
    int          checks = 0;
    int          fails = 0;

    int         m_row, m_run, m_rel;
    bit         m_held, m_valid, m_ovr;
    logic [3:0] m_pat, m_code;

    keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_TICKS(DT)) dut (
        .clk(clk), .reset(reset), .cols(cols), .key_read(key_read),
        .rows(rows), .key_data(key_data), .key_pressed(key_pressed)
    );

    always #5 clk = ~clk;

    // Pressed switch (r,c) shorts row r to column c
    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (press[r*4+c] && !rows[r]) cols[c] = 1'b0;
    end

    function automatic logic [3:0] kp(input int row, input logic [15:0] p);
        logic [3:0] s;
        s = 4'hF;
        for (int c = 0; c < 4; c++) if (p[row*4+c]) s[c] = 1'b0;
        return s;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_row = 0; m_run = 0; m_rel = 0; m_held = 0;
        m_pat = 4'hF; m_valid = 0; m_ovr = 0; m_code = 4'h0;
    endtask

    function automatic bit will_register();
        return !m_held && m_run == DT - 1 && kp(m_row, press) == m_pat;
    endfunction

    task automatic model_tick(input bit rd_early, input bit rd_late);
        logic [3:0] s;
        bit reg_now;
        int col;
        reg_now = 0;
        col = 0;
        if (rd_early) begin m_valid = 0; m_ovr = 0; end
        s = kp(m_row, press);
        if (!m_held) begin
            if (m_run == 0) begin
                if ($countones(~s) == 1) begin m_pat = s; m_run = 1; end
                else m_row = (m_row + 1) % 4;
            end else if (s == m_pat) begin
                m_run++;
            end else begin
                m_run = 0;
                m_row = (m_row + 1) % 4;
            end
            if (m_run == DT) begin reg_now = 1; m_held = 1; m_run = 0; end
        end else if (s == 4'hF) begin
            m_rel++;
            if (m_rel == DT) begin m_held = 0; m_rel = 0; m_row = (m_row + 1) % 4; end
        end else begin
            m_rel = 0;
        end
        if (reg_now) begin
            for (int c = 0; c < 4; c++) if (!m_pat[c]) col = c;
            m_code  = {m_row[1:0], col[1:0]};
            m_ovr   = m_valid && !rd_late;
            m_valid = 1;
        end else if (rd_late) begin
            m_valid = 0; m_ovr = 0;
        end
    endtask

    // Entered at the negedge right after a tick edge (prescaler at 0)
    task automatic tick(input bit rd_early, input bit rd_late);
        logic [3:0] one;
        key_read = rd_early;
        @(negedge clk);
        key_read = 1'b0;
        @(negedge clk);
        @(negedge clk);
        key_read = rd_late;
        @(negedge clk);
        key_read = 1'b0;
        model_tick(rd_early, rd_late);
        one = 4'b0001;
        check("rows", {4'b0, rows}, {4'b0, ~(one << m_row)});
        check("key_data", key_data, {m_valid, m_ovr, 2'b00, m_code});
        check("key_pressed", {7'b0, key_pressed}, {7'b0, m_held});
    endtask

    task automatic wait_held();
        for (int i = 0; i < 16 && !m_held; i++) tick(0, 0);
    endtask

    task automatic wait_free();
        press = '0;
        for (int i = 0; i < 16 && m_held; i++) tick(0, 0);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_rows", {4'b0, rows}, 8'h0E);
        check("rst_key_data", key_data, 8'h00);
        check("rst_pressed", {7'b0, key_pressed}, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_rows", {4'b0, rows}, 8'h0E);
        check("reset_key_data", key_data, 8'h00);
        check("reset_pressed", {7'b0, key_pressed}, 8'h00);
        reset = 1'b0;

        repeat (5) tick(0, 0);

        // Row 2 / col 1, long hold, then release with short bounce
        press = 16'(1) << 9;
        wait_held();
        check("press_89", key_data, 8'h89);
        check("frozen_row2", {4'b0, rows}, 8'h0B);
        repeat (20) tick(0, 0);
        check("no_repeat", key_data, 8'h89);
        press = '0; tick(0, 0); tick(0, 0);
        press = 16'(1) << 9; tick(0, 0);
        check("rel_bounce_held", {7'b0, key_pressed}, 8'h01);
        press = '0; repeat (3) tick(0, 0);
        check("released", {7'b0, key_pressed}, 8'h00);
        check("resume_row3", {4'b0, rows}, 8'h07);

        // Press bounce never registers, stable press does
        tick(1, 0);
        check("read_clears", key_data, 8'h09);
        for (int i = 0; i < 16; i++) begin
            press = (i % 2 == 1) ? (16'(1) << 9) : 16'h0;
            tick(0, 0);
        end
        check("bounce_nokey", {7'b0, key_data[7]}, 8'h00);
        press = 16'(1) << 9;
        wait_held();
        check("bounce_then_89", key_data, 8'h89);
        wait_free();
        tick(1, 0);

        // Overrun, read, and read coincident with registration
        press = 16'(1) << 0;  wait_held(); wait_free();
        press = 16'(1) << 15; wait_held();
        check("overrun_CF", key_data, 8'hCF);
        tick(1, 0);
        check("read_0F", key_data, 8'h0F);
        wait_free();
        press = 16'(1) << 5; wait_held();
        check("key_85", key_data, 8'h85);
        wait_free();
        press = 16'(1) << 10;
        for (int i = 0; i < 16 && !m_held; i++) tick(0, will_register());
        check("read_vs_reg_8A", key_data, 8'h8A);
        wait_free();

        // Reset mid-debounce, then mid-hold; held key is rescanned from row 0
        press = 16'(1) << 6;
        for (int i = 0; i < 16 && m_run == 0; i++) tick(0, 0);
        mid_reset();
        wait_held();
        check("rescan_86", key_data, 8'h86);
        mid_reset();
        wait_held();
        wait_free();
        tick(1, 0);

        // Two columns low in one row
        press = (16'(1) << 4) | (16'(1) << 6);
        repeat (12) tick(0, 0);
        check("multi_nokey", {7'b0, key_data[7]}, 8'h00);
        check("multi_notheld", {7'b0, key_pressed}, 8'h00);

        // Random keypad activity and reads
        press = '0;
        for (int i = 0; i < 160; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4: press = '0;
                    9:             press = (16'(1) << $urandom_range(0, 15)) |
                                           (16'(1) << $urandom_range(0, 15));
                    default:       press = 16'(1) << $urandom_range(0, 15);
                endcase
            end
            tick($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_TICKS, default 1000: clk cycles per scan tick (min 2).
REQ-002 SHALL have parameter DEBOUNCE_TICKS, default 4: consecutive stable ticks needed to accept a press or release (min 1).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cols  input  4  keypad column lines; active-low, pulled up externally, asynchronous to clk.
REQ-006 SHALL have port key_read  input  1  one-cycle read strobe from peripheral_controller; acknowledges key_data.
REQ-007 SHALL have port rows  output  4  keypad row drive; active-low, exactly one bit low.
REQ-008 SHALL have port key_data  output  8  {valid, overrun, 2'b00, code[3:0]}, read by peripheral_controller.
REQ-009 SHALL have port key_pressed  output  1  high while a debounced key is held.

Function
REQ-010 SHALL pass cols through a 2-flop synchronizer whose flops reset to 4'hF; all decisions use the synchronized value (scols).
REQ-011 SHALL run a prescaler counting 0..SCAN_TICKS-1 and wrapping; tick is high for one cycle when the count equals SCAN_TICKS-1.
REQ-012 SHALL drive rows = ~(4'b0001 << row_idx), with row_idx a 2-bit counter wrapping 3->0.
REQ-013 SHALL implement states SCAN, DEBOUNCE, HELD, RELEASE; each evaluates scols only on tick.
REQ-014 SCAN: scols==4'hF -> increment row_idx; scols one-hot-low -> latch scols as pat, db_cnt=1, go DEBOUNCE (row_idx held); more than one bit low -> increment row_idx, stay SCAN.
REQ-015 DEBOUNCE: scols==pat -> db_cnt+1; when db_cnt reaches DEBOUNCE_TICKS -> register key, go HELD; scols!=pat -> clear db_cnt, increment row_idx, go SCAN.
REQ-016 With DEBOUNCE_TICKS=1, the key SHALL be registered on the SCAN tick that detects it and the FSM SHALL go directly to HELD.
REQ-017 Registering a key SHALL set code = {row_idx, col_idx}, where col_idx is the index of the low bit of pat, and SHALL set valid=1.
REQ-018 If valid is already 1 when a key is registered, overrun SHALL be set to 1 and code overwritten with the new key.
REQ-019 HELD: scols==4'hF -> db_cnt=1, go RELEASE; any other value -> stay HELD; no further key registered (no auto-repeat).
REQ-020 RELEASE: scols==4'hF -> db_cnt+1; at DEBOUNCE_TICKS -> increment row_idx, go SCAN; any low bit -> clear db_cnt, go HELD.
REQ-021 key_pressed SHALL be 1 exactly in HELD and RELEASE.
REQ-022 key_read SHALL clear valid and overrun on the following edge; code SHALL be retained.
REQ-023 If key_read and key registration occur in the same cycle, registration SHALL win: valid=1, overrun=0, new code.
REQ-024 key_read while valid=0 SHALL have no effect.

Reset
REQ-025 Asserting reset SHALL immediately force: state SCAN, row_idx=0, rows=4'b1110, prescaler=0, db_cnt=0, key_data=8'h00, key_pressed=0, synchronizer=4'hF.
REQ-026 Reset asserted mid-debounce or mid-hold SHALL discard the pending key; after release, a key still held SHALL be rescanned from row 0 and re-debounced.

Verification (SCAN_TICKS=4, DEBOUNCE_TICKS=3)
REQ-027 Reset, cols=4'hF -> rows=1110, key_data=00, key_pressed=0; then rows steps 1110->1101->1011->0111->1110, one step per 4 clk.
REQ-028 Press row 2/col 1 (cols=4'b1101 only while rows=1011) -> after 3 stable ticks key_data=8'h89, key_pressed=1, rows frozen at 1011; hold 20 ticks -> no second registration.
REQ-029 Bounce: cols toggles 1101/1111 on alternate ticks -> key_data stays 00, scan continues; then stable press -> 8'h89.
REQ-030 Release with bounce shorter than 3 ticks -> key_pressed stays 1; after 3 clean 4'hF ticks key_pressed=0 and scanning resumes at row 3.
REQ-031 Two presses (code 0 then code F) without key_read -> key_data=8'hCF; key_read pulse -> 8'h0F; key_read coincident with a new registration -> valid=1, overrun=0.
REQ-032 Reset asserted mid-DEBOUNCE -> outputs at reset values immediately; two columns low simultaneously -> no key registered.
